pci_bus_arbiter: RTL and testbench

- Central arbiter for the shared PCI bus. Decides which initiator controller may start the next transaction.
- Takes REQ# from up to N_MASTERS initiators and drives the matching GNT# lines, using round-robin fairness.
- Watches FRAME#/IRDY# to track bus ownership. Parks the bus on a default master when no one is requesting.
- Sits beside the initiator/target controllers on the same bus clock.

---
 rtl/pci_bus_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: round-robin REQ#/GNT# arbiter for the shared PCI bus.
// Parks on a default master, revokes idle grants, registered outputs.
module pci_bus_arbiter #(
  parameter int N_MASTERS    = 4,
  parameter int PARK_MASTER  = 0,
  parameter int IDLE_TIMEOUT = 16,
  parameter int IDX_W        = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] req_n,
  input  logic                 frame_n,
  input  logic                 irdy_n,
  output logic [N_MASTERS-1:0] gnt_n,
  output logic [IDX_W-1:0]     owner,
  output logic                 bus_busy
);

  localparam int CNT_W =
    (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO =
    CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PARK_IDX =
    IDX_W'(PARK_MASTER);

  typedef enum logic [1:0] {
    S_PARK,
    S_GAP,
    S_GRANT,
    S_XFER
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic                   wvld_q, wvld_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_MASTERS-1:0]   gnt_n_q, gnt_n_d;
  logic                   busy_q, busy_d;

  logic [N_MASTERS-1:0]   req;
  logic [N_MASTERS-1:0]   own_oh;
  logic [N_MASTERS-1:0]   others;
  logic                   bus_idle;
  logic                   any_req;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       oth_idx;
  logic [IDX_W-1:0]       tmo_idx;

  function automatic logic [N_MASTERS-1:0] onehot(
    input logic [IDX_W-1:0] i
  );
    return N_MASTERS'(1) << i;
  endfunction

  // First requester after p, wrapping; p itself has lowest priority.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_MASTERS-1:0] r,
    input logic [IDX_W-1:0]     p
  );
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] i;
    res = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      i = IDX_W'((int'(p) + k) % N_MASTERS);
      if (r[i]) res = i;
    end
    return res;
  endfunction

  assign req      = ~req_n;
  assign bus_idle = frame_n & irdy_n;
  assign any_req  = |req;
  assign pick_idx = rr_pick(req, ptr_q);
  assign own_oh   = onehot(owner_q);
  assign others   = req & ~own_oh;
  assign oth_idx  = rr_pick(others, ptr_q);
  assign tmo_idx  = (|others) ? oth_idx : owner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_GAP;
      owner_q <= PARK_IDX;
      ptr_q   <= PARK_IDX;
      win_q   <= PARK_IDX;
      wvld_q  <= 1'b0;
      cnt_q   <= '0;
      gnt_n_q <= '1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wvld_q  <= wvld_d;
      cnt_q   <= cnt_d;
      gnt_n_q <= gnt_n_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    win_d   = win_q;
    wvld_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_PARK: begin
        cnt_d = '0;
        if (!frame_n) begin
          state_d = S_XFER;
          owner_d = PARK_IDX;
        end else if (any_req) begin
          if (pick_idx == PARK_IDX) begin
            state_d = S_GRANT;
            owner_d = PARK_IDX;
          end else begin
            state_d = S_GAP;
            win_d   = pick_idx;
            wvld_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        cnt_d = '0;
        if (wvld_q) begin
          state_d = S_GRANT;
          owner_d = win_q;
        end else if (any_req) begin
          state_d = S_GRANT;
          owner_d = pick_idx;
        end else begin
          state_d = S_PARK;
          owner_d = PARK_IDX;
        end
      end
      S_GRANT: begin
        if (!frame_n) begin
          state_d = S_XFER;
          cnt_d   = '0;
        end else if (bus_idle) begin
          if (!req[owner_q]) begin
            cnt_d = '0;
            if (any_req) begin
              state_d = S_GAP;
              win_d   = pick_idx;
              wvld_d  = 1'b1;
            end else if (owner_q == PARK_IDX) begin
              state_d = S_PARK;
            end else begin
              state_d = S_GAP;
            end
          end else if (cnt_q == TMO) begin
            state_d = S_GAP;
            win_d   = tmo_idx;
            wvld_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_XFER: begin
        cnt_d = '0;
        // ptr tracks owner here, so the owner only wins when alone
        if (bus_idle) begin
          if (any_req && pick_idx == owner_q) begin
            state_d = S_GRANT;
          end else if (any_req) begin
            state_d = S_GAP;
            win_d   = pick_idx;
            wvld_d  = 1'b1;
          end else if (owner_q == PARK_IDX) begin
            state_d = S_PARK;
          end else begin
            state_d = S_GAP;
          end
        end
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_d == S_GRANT || state_d == S_XFER) ptr_d = owner_d;
  end

  always_comb begin
    gnt_n_d = '1;
    busy_d  = ~bus_idle;
    unique case (state_d)
      S_PARK:  gnt_n_d = ~onehot(PARK_IDX);
      S_GRANT: gnt_n_d = ~onehot(owner_d);
      S_XFER: begin
        // once revoked, the grant stays off until the bus drains
        if (!gnt_n_q[owner_q] && others == '0)
          gnt_n_d = ~onehot(owner_d);
      end
      S_GAP:   gnt_n_d = '1;
    endcase
  end

  assign gnt_n    = gnt_n_q;
  assign owner    = owner_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb_pci_bus_arbiter: directed scoreboard bench for pci_bus_arbiter.
// Expected outputs are queued per cycle and compared on the falling edge.
module tb_pci_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req_n;
  logic       frame_n;
  logic       irdy_n;
  logic [3:0] gnt_n;
  logic [1:0] owner;
  logic       bus_busy;

  int n_chk = 0;
  int n_err = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  gnt;
    logic [1:0]  own;
    logic        busy;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  pci_bus_arbiter #(
    .N_MASTERS(4),
    .PARK_MASTER(0),
    .IDLE_TIMEOUT(16),
    .IDX_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_n(req_n),
    .frame_n(frame_n),
    .irdy_n(irdy_n),
    .gnt_n(gnt_n),
    .owner(owner),
    .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      cur = sb.pop_front();
      chk({cur.tag, ".gnt"}, 32'(gnt_n), 32'(cur.gnt));
      chk({cur.tag, ".own"}, 32'(owner), 32'(cur.own));
      chk({cur.tag, ".busy"}, 32'(bus_busy), 32'(cur.busy));
    end
  end

  function automatic logic [3:0] nb(input int m);
    logic [3:0] v;
    v = 4'b0001 << m;
    return ~v;
  endfunction

  task automatic step(
    input logic [3:0] rq,
    input logic       fr,
    input logic       ir,
    input logic [3:0] eg,
    input logic [1:0] eo,
    input logic       eb,
    input string      tag
  );
    exp_t e;
    req_n   = rq;
    frame_n = fr;
    irdy_n  = ir;
    e.cyc  = cyc + 1;
    e.gnt  = eg;
    e.own  = eo;
    e.busy = eb;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".gnt"}, 32'(gnt_n), 32'hF);
    chk({tag, ".own"}, 32'(owner), 32'h0);
    chk({tag, ".busy"}, 32'(bus_busy), 32'h0);
    req_n   = 4'hF;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_n   = 4'hF;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    #2;
    do_reset("rst0");

    // park after reset
    repeat (4) step(4'hF, 1, 1, 4'hE, 0, 0, "park");

    // single request from park, 3-clock transaction
    step(4'b1011, 1, 1, 4'hF, 0, 0, "t2_gap");
    step(4'b1011, 1, 1, 4'b1011, 2, 0, "t2_gnt");
    repeat (3) step(4'b1011, 0, 1, 4'b1011, 2, 1, "t2_xfer");
    step(4'hF, 1, 1, 4'hF, 2, 0, "t2_end");
    step(4'hF, 1, 1, 4'hE, 0, 0, "t2_park");

    // all request: round robin 1,2,3,0,1
    do_reset("rst1");
    step(4'hF, 1, 1, 4'hE, 0, 0, "t3_park");
    step(4'h0, 1, 1, 4'hF, 0, 0, "t3_gap0");
    for (int k = 0; k < 5; k++) begin
      int m;
      m = (1 + k) % 4;
      step(4'h0, 1, 1, nb(m), 2'(m), 0, "t3_gnt");
      step(4'h0, 0, 1, 4'hF, 2'(m), 1, "t3_rev");
      step(4'h0, 0, 1, 4'hF, 2'(m), 1, "t3_xfer");
      step(4'h0, 1, 1, 4'hF, 2'(m), 0, "t3_gap");
    end
    step(4'hF, 1, 1, 4'b1011, 2, 0, "t3_latched");
    step(4'hF, 1, 1, 4'hF, 2, 0, "t3_drop");
    step(4'hF, 1, 1, 4'hE, 0, 0, "t3_park2");

    // idle timeout, sole requester then with competitor
    step(4'b1101, 1, 1, 4'hF, 0, 0, "t4_gap");
    step(4'b1101, 1, 1, 4'b1101, 1, 0, "t4_gnt");
    repeat (15) step(4'b1101, 1, 1, 4'b1101, 1, 0, "t4_idle");
    step(4'b1101, 1, 1, 4'hF, 1, 0, "t4_tmo");
    step(4'b1101, 1, 1, 4'b1101, 1, 0, "t4_regnt");
    repeat (15) step(4'b0101, 1, 1, 4'b1101, 1, 0, "t4b_idle");
    step(4'b0101, 1, 1, 4'hF, 1, 0, "t4b_tmo");
    step(4'b0101, 1, 1, 4'b0111, 3, 0, "t4b_gnt3");
    step(4'hF, 1, 1, 4'hF, 3, 0, "t4_rel");
    step(4'hF, 1, 1, 4'hE, 0, 0, "t4_park");

    // park master transaction preempted by master 3
    step(4'hF, 0, 1, 4'hE, 0, 1, "t5_xfer");
    step(4'b0111, 0, 1, 4'hF, 0, 1, "t5_rev");
    step(4'b0111, 1, 0, 4'hF, 0, 1, "t5_irdy");
    step(4'b0111, 1, 1, 4'hF, 0, 0, "t5_gap");
    step(4'b0111, 1, 1, 4'b0111, 3, 0, "t5_gnt3");
    step(4'hF, 1, 1, 4'hF, 3, 0, "t5_rel");
    step(4'hF, 1, 1, 4'hE, 0, 0, "t5_park");

    // park master wins arbitration: no gap
    step(4'b1110, 1, 1, 4'hE, 0, 0, "pk_self");
    step(4'hF, 1, 1, 4'hE, 0, 0, "pk_drop");

    // frame in the same clock the timeout expires
    step(4'b1011, 1, 1, 4'hF, 0, 0, "ft_gap");
    step(4'b1011, 1, 1, 4'b1011, 2, 0, "ft_gnt");
    repeat (15) step(4'b1011, 1, 1, 4'b1011, 2, 0, "ft_idle");
    step(4'b1011, 0, 1, 4'b1011, 2, 1, "ft_frame");
    step(4'hF, 1, 1, 4'hF, 2, 0, "ft_end");
    step(4'hF, 1, 1, 4'hE, 0, 0, "ft_park");

    // asynchronous reset in the middle of a transaction
    step(4'b1011, 1, 1, 4'hF, 0, 0, "ar_gap");
    step(4'b1011, 1, 1, 4'b1011, 2, 0, "ar_gnt");
    step(4'b1011, 0, 1, 4'b1011, 2, 1, "ar_xfer");
    do_reset("ar_rst");
    step(4'hF, 1, 1, 4'hE, 0, 0, "ar_park");

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
